// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order ALU writebacks with buffered
// out-of-order load returns, with WAW kill, hazard query and starvation stall.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  chk_rd,
  output logic        chk_busy,
  output logic        stall_req,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [PW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             rw_q, rw_d;
  logic [4:0]       wr_q, wr_d;
  logic [31:0]      wd_q, wd_d;

  logic             full_s, empty_s, alu_wr_s, push_s, enq_s, pop_s, busy_s;
  logic [PW-1:0]    head_s, tail_s;
  logic [PW:0]      count_s;
  logic [PW-1:0]    off_s [DEPTH];

  assign empty_s  = (wptr_q == rptr_q);
  assign full_s   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count_s  = wptr_q - rptr_q;
  assign head_s   = rptr_q[PW-1:0];
  assign tail_s   = wptr_q[PW-1:0];
  assign alu_wr_s = alu_valid && (alu_rd != 5'd0);
  assign push_s   = ld_valid && !full_s;
  // A load whose destination the same-cycle ALU result overwrites is already stale.
  assign enq_s    = push_s && (ld_rd != 5'd0) && !(alu_wr_s && (alu_rd == ld_rd));
  assign pop_s    = !alu_wr_s && !empty_s;

  // Next-state for FIFO, write port and starvation tracking.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    live_d = live_q;
    rd_d   = rd_q;
    data_d = data_q;
    rw_d   = 1'b0;
    wr_d   = wr_q;
    wd_d   = wd_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_wr_s && (rd_q[i] == alu_rd)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_q[i];
      end
    end
    if (enq_s) begin
      live_d[tail_s] = 1'b1;
      rd_d[tail_s]   = ld_rd;
      data_d[tail_s] = ld_data;
      wptr_d         = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (alu_wr_s) begin
      rw_d = 1'b1;
      wr_d = alu_rd;
      wd_d = alu_data;
    end else if (pop_s) begin
      rw_d   = live_q[head_s];
      wr_d   = rd_q[head_s];
      wd_d   = data_q[head_s];
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rw_d = 1'b0;
    end
    if (empty_s || pop_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    // Holding on cnt_q keeps the stall up through the first draining pop.
    stall_d = (cnt_d == CNT_MAX) || (cnt_q == CNT_MAX);
  end

  // Distance of each slot from the head, used to qualify valid entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = PW'(i) - head_s;
    end
  end

  // Hazard query over the live, valid queued loads.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, off_s[i]} < count_s) && live_q[i] && (rd_q[i] == chk_rd) && (chk_rd != 5'd0)) begin
        busy_s = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      live_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      rw_q    <= 1'b0;
      wr_q    <= 5'd0;
      wd_q    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      live_q  <= live_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      rw_q    <= rw_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign ld_ready      = !full_s;
  assign chk_busy      = busy_s;
  assign stall_req     = stall_q;
  assign RegWrite      = rw_q;
  assign WriteRegister = wr_q;
  assign WriteData     = wd_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side master for the CPU register file. Merges in-order ALU/CSR writeback results with out-of-order load returns from the data-memory path into the register file's single write port (RegWrite / WriteRegister / WriteData).
- Load returns are buffered in a small FIFO. ALU writes have priority.
- Provides a pending-destination query for the hazard unit, and a stall request when a queued load is starved of the write port.

Parameters:
- DEPTH, 2, load-return FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may go without popping before stall_req asserts

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU/CSR writeback valid this cycle (always accepted, no ready)
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- ld_valid  input  1  load return valid
- ld_rd  input  5  load destination register
- ld_data  input  32  load data, already aligned and extended
- ld_ready  output  1  load return accepted when ld_valid && ld_ready
- chk_rd  input  5  hazard-unit query register
- chk_busy  output  1  a live queued load targets chk_rd
- stall_req  output  1  request a pipeline bubble so the FIFO can drain
- RegWrite  output  1  register-file write enable
- WriteRegister  output  5  register-file write address
- WriteData  output  32  register-file write data

Behaviour:
- Interface: one clock clk; reset resetn is asynchronous, active-low.
- Reset values:
  - RegWrite=0, WriteRegister=0, WriteData=0, stall_req=0.
  - FIFO empty; all entry live bits cleared; starvation counter=0.
  - Reset mid-operation discards all queued loads.
- FIFO:
  - Entry = {live, rd[4:0], data[31:0]}.
  - Read/write pointers are log2(DEPTH)+1 bits; full/empty are decided from the pointer MSB compare.
  - ld_ready = !full (combinational from state only; no same-cycle push-through when full). It is 1 after reset.
- Push (edge where ld_valid && ld_ready):
  - ld_rd==0: accepted and discarded, no enqueue.
  - Simultaneous alu_valid with alu_rd==ld_rd (nonzero): accepted and discarded. The ALU result is younger.
  - Otherwise enqueue with live=1.
- Arbitration at each rising edge (output registers, 1-cycle latency):
  - alu_valid && alu_rd!=0: RegWrite<=1, WriteRegister<=alu_rd, WriteData<=alu_data. No pop.
  - Else FIFO non-empty: pop head. RegWrite<=head.live, WriteRegister<=head.rd, WriteData<=head.data. A dead head pops with RegWrite<=0.
  - Else RegWrite<=0. WriteRegister and WriteData hold their previous values.
- alu_valid with alu_rd==0: treated as no ALU write; the FIFO may pop that cycle.
- WAW kill: on an edge with alu_valid && alu_rd!=0, every queued entry with rd==alu_rd has live cleared. A newly pushed entry on the same edge is handled by the push rule above.
- Latency:
  - ALU sampled at edge E → RegWrite visible after E.
  - Load accepted at E → earliest RegWrite after E+1.
- Push and pop on the same edge are both performed; occupancy is unchanged.
- chk_busy: combinational OR over valid FIFO entries of (live && rd==chk_rd && chk_rd!=0). An entry is valid when its index lies between rptr and wptr.
- Starvation counter:
  - Increments on each edge where the FIFO is non-empty and alu_valid blocks the pop; saturates at STARVE_MAX.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is registered, =1 while counter==STARVE_MAX. It clears on the edge after the next pop.
- Wrap-around: pointers wrap modulo 2*DEPTH. Back-to-back fill/drain across the wrap point must preserve FIFO order.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF. Following cycle RegWrite=0.
- Load rd=7 data=0x11, then rd=8 data=0x22 with alu_valid=0 → RegWrite pulses for rd 7 then rd 8, in order, earliest one cycle after each accept. ld_ready stays 1.
- Push 2 loads while alu_valid=1 continuously (rd≠load rd) → ld_ready=0 when full, chk_busy=1 for queried load rd. stall_req=1 after 4 blocked edges. Drop alu_valid → both loads drain, stall_req returns to 0.
- Queue load rd=3 data=0xAA, then ALU write rd=3 data=0xBB while blocked → register 3 written 0xBB. The dead entry pops with RegWrite=0. chk_busy(3)=0 after the kill.
- Same edge: ld_valid rd=9 and alu_valid rd=9 → only the ALU write occurs; FIFO stays empty. Load rd=0 is accepted, with no write and no enqueue.
- Fill FIFO, assert resetn=0 asynchronously mid-drain → outputs immediately 0, FIFO empty, ld_ready=1 after release. Then 6 push/pop pairs across the wrap point keep order.
